instr_register_pipe: RTL and testbench
======================================

// Module: instr_register_pipe
// PURPOSE
//  Parametrised instruction register with integrated execute stage. Each accepted write carries opcode/op_a/op_b;
//  block computes the result (ZERO,PASSA,PASSB,ADD,SUB,MULT,DIV,MOD) and stores {opc,op_a,op_b,res,flags} per entry.
//  Sits between the instruction-issue driver and the read-back/checker path; DIV/MOD run on a multi-cycle iterative
//  divider with load_ready backpressure, all other ops at full throughput.
// PARAMETERS
//  OP_W    32              operand width, signed two's complement
//  DEPTH   32              number of entries; power of 2, >=2
//  ADDR_W  $clog2(DEPTH)   pointer width (derived)
//  RES_W   2*OP_W          result width, signed
// PORTS
//  clk            in   1       single clock, all state on posedge
//  reset          in   1       asynchronous, active-high
//  load_en        in   1       write request valid
//  load_ready     out  1       block can accept a write this cycle
//  write_pointer  in   ADDR_W  destination entry
//  opcode         in   3       0 ZERO,1 PASSA,2 PASSB,3 ADD,4 SUB,5 MULT,6 DIV,7 MOD
//  operand_a      in   OP_W    signed
//  operand_b      in   OP_W    signed
//  read_en        in   1       read request
//  read_pointer   in   ADDR_W  entry to read
//  read_valid     out  1       rd_* valid this cycle (1-cycle pulse)
//  rd_opcode      out  3       stored opcode
//  rd_op_a        out  OP_W    stored op_a
//  rd_op_b        out  OP_W    stored op_b
//  rd_result      out  RES_W   stored result
//  rd_entry_valid out  1       entry written since reset
//  rd_div0        out  1       entry was DIV/MOD with op_b==0
// BEHAVIOUR
//  Reset (async assert): all entries {0,0,0,0,valid=0,div0=0}; all outputs 0, load_ready=0; divider aborted, no
//   partial write. First posedge after release: load_ready=1, FSM=IDLE.
//  Accept = load_en & load_ready at posedge T0; inputs captured in stage reg; load_en while !load_ready is ignored.
//  FSM: IDLE -> EXEC on accept of opc 0..5; IDLE -> DIVIDE on accept of opc 6/7.
//   EXEC: result computed, entry written at T0+1; load_ready stays 1 (back-to-back accepts allowed; EXEC->EXEC/DIVIDE/IDLE).
//   DIVIDE: load_ready=0 from T0+1; restoring radix-2 on |op_a|,|op_b|, exactly OP_W cycles; entry written at T0+OP_W+1;
//    load_ready=1 again in that same cycle, returns to IDLE.
//   op_b==0 in DIV/MOD: skip iteration, result=0, div0=1, written at T0+1 like EXEC.
//  Arithmetic (operands sign-extended to RES_W): ADD/SUB exact, MULT full signed product, no overflow possible.
//   DIV truncates toward zero; MOD sign follows op_a (a == q*b + r). PASSA/PASSB sign-extend. ZERO -> 0.
//   Most-negative/-1: quotient +2^(OP_W-1), representable in RES_W.
//  Every write sets entry valid=1; div0 updated (0 for non-div ops). Rewrite of same pointer overwrites all fields.
//  Read: read_en at posedge T -> rd_* and read_valid=1 at T+1; read_valid=0 next cycle unless read_en held.
//   Reads accepted every cycle, independent of load_ready/FSM state.
//   Read and entry write same edge, same address: read returns OLD contents (read-before-write); no forwarding of
//   in-flight (stage/divider) data.
//  Pointers wrap naturally (ADDR_W bits, DEPTH power of 2); no out-of-range case.
// TESTING (OP_W=8, DEPTH=16 unless noted)
//  1 Reset, read all 16 -> rd_entry_valid=0, rd_result=0; load_ready=0 in reset, 1 one edge after release.
//  2 Back-to-back ADD(-15,15)@0, SUB(-8,7)@1, MULT(-128,-128)@2 -> load_ready never drops; results 0,-15,16384.
//  3 DIV(-7,2)@3 -> load_ready low 8 cycles, entry written T0+9, result -3; MOD(-7,2)@4 -> -1; DIV(-128,-1) -> 128.
//  4 DIV(5,0)@5 and MOD(5,0)@6 -> result 0, div0=1, written T0+1, no load_ready drop.
//  5 read_en@7 on same edge as write@7 -> old data returned; re-read next cycle -> new data.
//  6 Assert reset mid-DIVIDE (cycle 4 of 8) -> target entry stays invalid, load_ready=0 then 1, next write accepted.
//  Plus randomized run (OP_W=32, DEPTH=32) vs reference model, including DIV/MOD with load_en held during backpressure.

Source files
------------

// File: rtl/instr_register_pipe.sv
// Instruction register with an integrated execute stage: each accepted write is evaluated
// (ALU ops in one cycle, DIV/MOD on an OP_W-cycle restoring divider) and stored per entry.
module instr_register_pipe #(
    parameter int OP_W   = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RES_W  = 2 * OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] write_pointer,
    input  logic [2:0]        opcode,
    input  logic [OP_W-1:0]   operand_a,
    input  logic [OP_W-1:0]   operand_b,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_pointer,
    output logic              read_valid,
    output logic [2:0]        rd_opcode,
    output logic [OP_W-1:0]   rd_op_a,
    output logic [OP_W-1:0]   rd_op_b,
    output logic [RES_W-1:0]  rd_result,
    output logic              rd_entry_valid,
    output logic              rd_div0
);

    localparam int CNT_W = $clog2(OP_W + 1);

    localparam logic [2:0] OPC_ZERO  = 3'd0;
    localparam logic [2:0] OPC_PASSA = 3'd1;
    localparam logic [2:0] OPC_PASSB = 3'd2;
    localparam logic [2:0] OPC_ADD   = 3'd3;
    localparam logic [2:0] OPC_SUB   = 3'd4;
    localparam logic [2:0] OPC_MULT  = 3'd5;
    localparam logic [2:0] OPC_DIV   = 3'd6;
    localparam logic [2:0] OPC_MOD   = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, DIVIDE} state_t;

    typedef struct packed {
        logic [2:0]       opc;
        logic [OP_W-1:0]  op_a;
        logic [OP_W-1:0]  op_b;
        logic [RES_W-1:0] res;
        logic             valid;
        logic             div0;
    } entry_t;

    state_t            state, next_state;
    logic              ready_q;
    logic              accept, in_div, busy, div_done, wr_en;
    logic [2:0]        stage_opc;
    logic [OP_W-1:0]   stage_a, stage_b;
    logic [ADDR_W-1:0] stage_ptr;
    logic [OP_W-1:0]   div_rem, div_quo, div_dvs;
    logic [CNT_W-1:0]  div_cnt;
    logic [OP_W:0]     div_partial, div_diff;
    logic [OP_W-1:0]   a_mag, b_mag;
    logic [RES_W-1:0]  a_ext, b_ext, q_mag, r_mag, wr_res;
    logic              wr_div0;
    entry_t            wr_entry, rd_entry;
    entry_t            mem [DEPTH];

    assign accept   = load_en && load_ready;
    assign in_div   = (opcode == OPC_DIV || opcode == OPC_MOD) && (operand_b != '0);
    assign div_done = (div_cnt == CNT_W'(OP_W));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= 1'b1;
        end
    end

    // Next-state logic; a divide that finishes this cycle may hand over to a new accept
    always_comb begin
        // NOTE: default assignment first so no path through the block infers a latch.
        next_state = IDLE;
        if (busy)
            next_state = DIVIDE;
        else if (accept)
            next_state = in_div ? DIVIDE : EXEC;
    end

    // Output logic
    always_comb begin
        busy       = (state == DIVIDE) && !div_done;
        load_ready = ready_q && !busy;
        wr_en      = (state == EXEC) || ((state == DIVIDE) && div_done);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_opc <= '0;
            stage_a   <= '0;
            stage_b   <= '0;
            stage_ptr <= '0;
        end else if (accept) begin
            stage_opc <= opcode;
            stage_a   <= operand_a;
            stage_b   <= operand_b;
            stage_ptr <= write_pointer;
        end
    end

    // Restoring divider on magnitudes; most-negative magnitude still fits unsigned OP_W
    always_comb begin
        a_mag       = operand_a[OP_W-1] ? (~operand_a + 1'b1) : operand_a;
        b_mag       = operand_b[OP_W-1] ? (~operand_b + 1'b1) : operand_b;
        div_partial = {div_rem, div_quo[OP_W-1]};
        div_diff    = div_partial - {1'b0, div_dvs};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_rem <= '0;
            div_quo <= '0;
            div_dvs <= '0;
            div_cnt <= '0;
        end else if (accept && in_div) begin
            div_rem <= '0;
            div_quo <= a_mag;
            div_dvs <= b_mag;
            div_cnt <= '0;
        end else if (busy) begin
            div_rem <= div_diff[OP_W] ? div_partial[OP_W-1:0] : div_diff[OP_W-1:0];
            div_quo <= {div_quo[OP_W-2:0], ~div_diff[OP_W]};
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        a_ext   = {{(RES_W-OP_W){stage_a[OP_W-1]}}, stage_a};
        b_ext   = {{(RES_W-OP_W){stage_b[OP_W-1]}}, stage_b};
        q_mag   = {{(RES_W-OP_W){1'b0}}, div_quo};
        r_mag   = {{(RES_W-OP_W){1'b0}}, div_rem};
        wr_div0 = (stage_opc == OPC_DIV || stage_opc == OPC_MOD) && (stage_b == '0);
        wr_res  = '0;
        case (stage_opc)
            OPC_ZERO:  wr_res = '0;
            OPC_PASSA: wr_res = a_ext;
            OPC_PASSB: wr_res = b_ext;
            OPC_ADD:   wr_res = a_ext + b_ext;
            OPC_SUB:   wr_res = a_ext - b_ext;
            OPC_MULT:  wr_res = a_ext * b_ext;
            OPC_DIV:   if (!wr_div0) wr_res = (stage_a[OP_W-1] ^ stage_b[OP_W-1]) ? -q_mag : q_mag;
            OPC_MOD:   if (!wr_div0) wr_res = stage_a[OP_W-1] ? -r_mag : r_mag;
            default:   wr_res = '0;
        endcase
        wr_entry = '{opc: stage_opc, op_a: stage_a, op_b: stage_b, res: wr_res, valid: 1'b1, div0: wr_div0};
    end

    // NOTE: the entry array is flop-based and cleared on reset, since valid/div0 must read 0 afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[stage_ptr] <= wr_entry;
        end
    end

    // Same-edge read of the entry being written sees the old contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_entry   <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= read_en;
            if (read_en)
                rd_entry <= mem[read_pointer];
        end
    end

    assign rd_opcode      = rd_entry.opc;
    assign rd_op_a        = rd_entry.op_a;
    assign rd_op_b        = rd_entry.op_b;
    assign rd_result      = rd_entry.res;
    assign rd_entry_valid = rd_entry.valid;
    assign rd_div0        = rd_entry.div0;

endmodule

// File: tb/tb_instr_register_pipe.sv
// Bench: directed timing/arith checks on an 8-bit/16-entry instance, randomized run on a
// 32-bit/32-entry instance against a behavioural model of the register file.
module tb_instr_register_pipe;

    localparam int S_OP = 8;
    localparam int S_RES = 16;
    localparam int L_OP = 32;
    localparam int L_RES = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              s_reset, s_load_en, s_load_ready, s_read_en, s_read_valid, s_rd_ev, s_rd_div0;
    logic [3:0]        s_wptr, s_rptr;
    logic [2:0]        s_opc, s_rd_opc;
    logic [S_OP-1:0]   s_a, s_b, s_rd_a, s_rd_b;
    logic [S_RES-1:0]  s_rd_res;

    logic              l_reset, l_load_en, l_load_ready, l_read_en, l_read_valid, l_rd_ev, l_rd_div0;
    logic [4:0]        l_wptr, l_rptr;
    logic [2:0]        l_opc, l_rd_opc;
    logic [L_OP-1:0]   l_a, l_b, l_rd_a, l_rd_b;
    logic [L_RES-1:0]  l_rd_res;

    instr_register_pipe #(.OP_W(S_OP), .DEPTH(16)) dut_s (
        .clk(clk), .reset(s_reset), .load_en(s_load_en), .load_ready(s_load_ready),
        .write_pointer(s_wptr), .opcode(s_opc), .operand_a(s_a), .operand_b(s_b),
        .read_en(s_read_en), .read_pointer(s_rptr), .read_valid(s_read_valid),
        .rd_opcode(s_rd_opc), .rd_op_a(s_rd_a), .rd_op_b(s_rd_b), .rd_result(s_rd_res),
        .rd_entry_valid(s_rd_ev), .rd_div0(s_rd_div0)
    );

    instr_register_pipe #(.OP_W(L_OP), .DEPTH(32)) dut_l (
        .clk(clk), .reset(l_reset), .load_en(l_load_en), .load_ready(l_load_ready),
        .write_pointer(l_wptr), .opcode(l_opc), .operand_a(l_a), .operand_b(l_b),
        .read_en(l_read_en), .read_pointer(l_rptr), .read_valid(l_read_valid),
        .rd_opcode(l_rd_opc), .rd_op_a(l_rd_a), .rd_op_b(l_rd_b), .rd_result(l_rd_res),
        .rd_entry_valid(l_rd_ev), .rd_div0(l_rd_div0)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Read one entry of the small instance; outputs are valid on return
    task automatic s_read(input int ptr);
        s_read_en = 1'b1;
        s_rptr    = ptr[3:0];
        @(negedge clk);
        s_read_en = 1'b0;
    endtask

    // Issue one write, measure load_ready low time, read on the write edge (old) then after (new)
    task automatic s_write_probe(input string name, input int opc, input int a, input int b, input int ptr,
                                 input int exp_low, input int old_valid, input int old_res,
                                 input int exp_res, input int exp_div0);
        int low;
        check({name, " ready before"}, s_load_ready, 1);
        s_load_en = 1'b1;
        s_opc = opc[2:0]; s_a = a[7:0]; s_b = b[7:0]; s_wptr = ptr[3:0];
        @(negedge clk);
        s_load_en = 1'b0;
        low = 0;
        while (s_load_ready !== 1'b1 && low < 40) begin
            low++;
            @(negedge clk);
        end
        check({name, " ready low cycles"}, low, exp_low);
        s_read_en = 1'b1;
        s_rptr    = ptr[3:0];
        @(negedge clk);
        check({name, " read_valid"}, s_read_valid, 1);
        check({name, " old valid"}, s_rd_ev, old_valid);
        check({name, " old result"}, $signed(s_rd_res), old_res);
        @(negedge clk);
        s_read_en = 1'b0;
        check({name, " new valid"}, s_rd_ev, 1);
        check({name, " new result"}, $signed(s_rd_res), exp_res);
        check({name, " new div0"}, s_rd_div0, exp_div0);
        @(negedge clk);
        check({name, " read_valid drops"}, s_read_valid, 0);
    endtask

    typedef struct {
        int opc;
        int a;
        int b;
        int ptr;
        int res;
        int div0;
    } vec_t;

    // Behavioural reference: results straight from integer arithmetic semantics
    function automatic longint ref_res(input int opc, input longint a, input longint b);
        case (opc)
            1: return a;
            2: return b;
            3: return a + b;
            4: return a - b;
            5: return a * b;
            6: return (b == 0) ? 0 : a / b;
            7: return (b == 0) ? 0 : a % b;
            default: return 0;
        endcase
    endfunction

    function automatic longint pick_operand();
        int sel;
        int v;
        sel = $urandom_range(0, 9);
        case (sel)
            0: v = 32'sh8000_0000;
            1: v = -1;
            2: v = 0;
            3: v = 32'sh7fff_ffff;
            4: v = $urandom_range(0, 20) - 10;
            default: v = $urandom;
        endcase
        return longint'(v);
    endfunction

    typedef struct {
        int       ptr;
        int       opc;
        longint   a;
        longint   b;
        longint   res;
        bit       div0;
        int       wedge;
    } pend_t;

    vec_t   vecs [16];
    pend_t  pq [$];
    int     m_opc [32];
    longint m_a [32], m_b [32], m_res [32];
    bit     m_valid [32], m_div0 [32];

    initial begin
        int waitc;
        s_reset = 1'b1; s_load_en = 1'b0; s_read_en = 1'b0;
        s_wptr = '0; s_rptr = '0; s_opc = '0; s_a = '0; s_b = '0;
        l_reset = 1'b1; l_load_en = 1'b0; l_read_en = 1'b0;
        l_wptr = '0; l_rptr = '0; l_opc = '0; l_a = '0; l_b = '0;

        vecs[0]  = '{3,  -15,   15,  0,      0, 0};
        vecs[1]  = '{4,   -8,    7,  1,    -15, 0};
        vecs[2]  = '{5, -128, -128,  2,  16384, 0};
        vecs[3]  = '{6,   -7,    2,  3,     -3, 0};
        vecs[4]  = '{7,   -7,    2,  4,     -1, 0};
        vecs[5]  = '{6,    5,    0,  5,      0, 1};
        vecs[6]  = '{7,    5,    0,  6,      0, 1};
        vecs[7]  = '{6, -128,   -1,  7,    128, 0};
        vecs[8]  = '{7, -128,   -1,  8,      0, 0};
        vecs[9]  = '{6,    7,   -2,  9,     -3, 0};
        vecs[10] = '{7,    7,   -2, 10,      1, 0};
        vecs[11] = '{1,   -5,    9, 11,     -5, 0};
        vecs[12] = '{2,    9, -100, 12,   -100, 0};
        vecs[13] = '{0,    3,    4, 13,      0, 0};
        vecs[14] = '{5,  127, -128, 14, -16256, 0};
        vecs[15] = '{6,  127,  127, 15,      1, 0};

        // Reset behaviour
        repeat (3) @(negedge clk);
        check("ready in reset", s_load_ready, 0);
        check("read_valid in reset", s_read_valid, 0);
        s_reset = 1'b0;
        #1;
        check("ready before first edge", s_load_ready, 0);
        @(negedge clk);
        check("ready after first edge", s_load_ready, 1);
        for (int i = 0; i < 16; i++) begin
            s_read(i);
            check("reset entry valid", s_rd_ev, 0);
            check("reset entry result", $signed(s_rd_res), 0);
        end

        // Back-to-back ALU writes: load_ready must hold high every cycle
        for (int i = 0; i < 3; i++) begin
            check("b2b ready", s_load_ready, 1);
            s_load_en = 1'b1;
            s_opc = vecs[i].opc[2:0]; s_a = vecs[i].a[7:0]; s_b = vecs[i].b[7:0]; s_wptr = vecs[i].ptr[3:0];
            @(negedge clk);
        end
        s_load_en = 1'b0;
        check("b2b ready after", s_load_ready, 1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            s_read(vecs[i].ptr);
            check("b2b result", $signed(s_rd_res), vecs[i].res);
        end

        // Multi-cycle divides, div-by-zero bypass, same-edge read/write
        s_write_probe("div -7/2",    6,   -7,  2, 3, 8, 0, 0,  -3, 0);
        s_write_probe("mod -7%2",    7,   -7,  2, 4, 8, 0, 0,  -1, 0);
        s_write_probe("div 5/0",     6,    5,  0, 5, 0, 0, 0,   0, 1);
        s_write_probe("mod 5%0",     7,    5,  0, 6, 0, 0, 0,   0, 1);
        s_write_probe("pass 7",      1,   11,  0, 7, 0, 0, 0,  11, 0);
        s_write_probe("rewrite 7",   3,   20, 22, 7, 0, 1, 11, 42, 0);
        s_write_probe("div -128/-1", 6, -128, -1, 8, 8, 0, 0, 128, 0);

        // Reset during a divide: entry must stay invalid, block recovers
        check("pre-abort ready", s_load_ready, 1);
        s_load_en = 1'b1; s_opc = 3'd6; s_a = 8'd100; s_b = 8'd3; s_wptr = 4'd9;
        @(negedge clk);
        s_load_en = 1'b0;
        repeat (3) @(negedge clk);
        check("mid-divide ready", s_load_ready, 0);
        s_reset = 1'b1;
        #1;
        check("abort ready in reset", s_load_ready, 0);
        @(negedge clk);
        s_reset = 1'b0;
        #1;
        check("abort ready before edge", s_load_ready, 0);
        @(negedge clk);
        check("abort ready after edge", s_load_ready, 1);
        repeat (12) @(negedge clk);
        s_read(9);
        check("aborted entry valid", s_rd_ev, 0);
        s_read(3);
        check("reset cleared entry", s_rd_ev, 0);
        s_write_probe("post-abort add", 3, 1, 2, 9, 0, 0, 0, 3, 0);

        // Table: write every vector (waiting out backpressure), then read back
        foreach (vecs[i]) begin
            waitc = 0;
            while (s_load_ready !== 1'b1 && waitc < 40) begin
                waitc++;
                @(negedge clk);
            end
            if (waitc >= 40) check("table ready timeout", waitc, 0);
            s_load_en = 1'b1;
            s_opc = vecs[i].opc[2:0]; s_a = vecs[i].a[7:0]; s_b = vecs[i].b[7:0]; s_wptr = vecs[i].ptr[3:0];
            @(negedge clk);
            s_load_en = 1'b0;
        end
        repeat (12) @(negedge clk);
        foreach (vecs[i]) begin
            s_read(vecs[i].ptr);
            check("table opcode", s_rd_opc, vecs[i].opc);
            check("table op_a", $signed(s_rd_a), vecs[i].a);
            check("table op_b", $signed(s_rd_b), vecs[i].b);
            check("table result", $signed(s_rd_res), vecs[i].res);
            check("table valid", s_rd_ev, 1);
            check("table div0", s_rd_div0, vecs[i].div0);
        end

        // Randomized run on the wide instance
        for (int i = 0; i < 32; i++) begin
            m_opc[i] = 0; m_a[i] = 0; m_b[i] = 0; m_res[i] = 0; m_valid[i] = 0; m_div0[i] = 0;
        end
        @(negedge clk);
        l_reset = 1'b0;
        @(negedge clk);
        begin
            int     ready_edge;
            bit     req, rd_pend, ready_m;
            int     r_opc, r_ptr, e_ptr;
            longint r_a, r_b;
            pend_t  p;
            ready_edge = 0;
            req = 0; rd_pend = 0;
            r_opc = 0; r_ptr = 0; r_a = 0; r_b = 0; e_ptr = 0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                // Outputs of the read captured at the previous edge
                check("rnd read_valid", l_read_valid, rd_pend);
                if (rd_pend) begin
                    check("rnd opcode", l_rd_opc, m_opc[e_ptr]);
                    check("rnd op_a", $signed(l_rd_a), m_a[e_ptr]);
                    check("rnd op_b", $signed(l_rd_b), m_b[e_ptr]);
                    check("rnd result", l_rd_res, m_res[e_ptr]);
                    check("rnd valid", l_rd_ev, m_valid[e_ptr]);
                    check("rnd div0", l_rd_div0, m_div0[e_ptr]);
                end
                // Writes landing on earlier edges are visible to a read at this edge
                while (pq.size() > 0 && pq[0].wedge < cyc) begin
                    p = pq.pop_front();
                    m_opc[p.ptr] = p.opc; m_a[p.ptr] = p.a; m_b[p.ptr] = p.b;
                    m_res[p.ptr] = p.res; m_valid[p.ptr] = 1; m_div0[p.ptr] = p.div0;
                end
                ready_m = (cyc >= ready_edge);
                check("rnd load_ready", l_load_ready, ready_m);
                // A refused request is held unchanged until accepted
                if (!req && $urandom_range(0, 9) < 7) begin
                    req   = 1;
                    r_opc = $urandom_range(0, 7);
                    r_ptr = $urandom_range(0, 31);
                    r_a   = pick_operand();
                    r_b   = pick_operand();
                end
                l_load_en = req;
                l_opc = r_opc[2:0]; l_wptr = r_ptr[4:0]; l_a = r_a[31:0]; l_b = r_b[31:0];
                if (req && ready_m) begin
                    p.ptr = r_ptr; p.opc = r_opc; p.a = r_a; p.b = r_b;
                    p.res  = ref_res(r_opc, r_a, r_b);
                    p.div0 = (r_opc >= 6) && (r_b == 0);
                    if (r_opc >= 6 && r_b != 0) begin
                        p.wedge    = cyc + L_OP + 1;
                        ready_edge = cyc + L_OP + 1;
                    end else begin
                        p.wedge = cyc + 1;
                    end
                    pq.push_back(p);
                    req = 0;
                end
                rd_pend   = ($urandom_range(0, 1) == 1);
                e_ptr     = $urandom_range(0, 31);
                l_read_en = rd_pend;
                l_rptr    = e_ptr[4:0];
                @(negedge clk);
            end
            l_load_en = 1'b0;
            l_read_en = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
